ttt_match_sequencer: RTL and testbench

Match-level scheduler for the tic-tac-toe game core. It arbitrates the player and computer move requesters with strict turn alternation and a per-turn timeout. It issues single-cycle move commands to the core's `play`/`pc` inputs, reads back the core's win, draw and illegal status, keeps per-side scores, clears the board between games, and declares a best-of match winner.

---
 rtl/ttt_match_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ttt_match_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ttt_match_sequencer.sv
// Match scheduler for the tic-tac-toe core: alternates player/computer moves with a turn
// timeout, issues move commands, tracks scores and declares the best-of match winner.
module ttt_match_sequencer #(
    parameter int unsigned WINS_TO_MATCH = 2,
    parameter int unsigned TURN_TIMEOUT  = 255,
    parameter int unsigned SCORE_W       = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pl_req,
    input  logic [3:0]         pl_pos,
    input  logic               pc_req,
    input  logic [3:0]         pc_pos,
    output logic               pl_ack,
    output logic               pc_ack,
    input  logic               game_illegal,
    input  logic               game_win,
    input  logic [1:0]         game_who,
    input  logic               game_full,
    output logic               play,
    output logic               pc,
    output logic [3:0]         move_pos,
    output logic               board_clear,
    output logic               turn,
    output logic               timeout_flag,
    output logic [SCORE_W-1:0] pl_score,
    output logic [SCORE_W-1:0] pc_score,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    localparam int unsigned CNT_W = $clog2(TURN_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WINS_TO_MATCH);

    typedef enum logic [2:0] {
        StIdle, StClear, StWait, StIssue, StSettle, StCheck, StDone
    } state_e;

    state_e             state_q, state_d;
    logic               turn_q, turn_d;
    logic               starter_q, starter_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         move_pos_q, move_pos_d;
    logic [SCORE_W-1:0] pl_score_q, pl_score_d;
    logic [SCORE_W-1:0] pc_score_q, pc_score_d;
    logic [1:0]         winner_q, winner_d;

    logic               req_hit;
    logic [SCORE_W-1:0] pl_sat, pc_sat;
    logic               pl_wins, pc_wins;

    assign req_hit = turn_q ? pc_req : pl_req;
    assign pl_sat  = (&pl_score_q) ? pl_score_q : pl_score_q + SCORE_W'(1);
    assign pc_sat  = (&pc_score_q) ? pc_score_q : pc_score_q + SCORE_W'(1);
    assign pl_wins = game_win && (game_who == 2'b01);
    assign pc_wins = game_win && (game_who == 2'b10);

    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        starter_d    = starter_q;
        cnt_d        = cnt_q;
        move_pos_d   = move_pos_q;
        pl_score_d   = pl_score_q;
        pc_score_d   = pc_score_q;
        winner_d     = winner_q;
        pl_ack       = 1'b0;
        pc_ack       = 1'b0;
        play         = 1'b0;
        pc           = 1'b0;
        board_clear  = 1'b0;
        timeout_flag = 1'b0;
        match_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                pl_score_d = '0;
                pc_score_d = '0;
                starter_d  = 1'b0;
                turn_d     = 1'b0;
                winner_d   = 2'b00;
                if (start) state_d = StClear;
            end
            StClear: begin
                board_clear = 1'b1;
                turn_d      = starter_q;
                cnt_d       = '0;
                state_d     = StWait;
            end
            StWait: begin
                // A request in the timeout cycle still wins over the timeout.
                if (req_hit) begin
                    move_pos_d = turn_q ? pc_pos : pl_pos;
                    state_d    = StIssue;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_flag = 1'b1;
                    turn_d       = ~turn_q;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StIssue: begin
                play   = 1'b1;
                pc     = turn_q;
                pl_ack = ~turn_q;
                pc_ack = turn_q;
                if (game_illegal) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    state_d = StSettle;
                end
            end
            StSettle: state_d = StCheck;
            StCheck: begin
                if (game_win) begin
                    if (pl_wins) pl_score_d = pl_sat;
                    if (pc_wins) pc_score_d = pc_sat;
                    if ((pl_wins && pl_sat == WIN_SCORE) || (pc_wins && pc_sat == WIN_SCORE)) begin
                        winner_d = game_who;
                        state_d  = StDone;
                    end else begin
                        starter_d = ~starter_q;
                        state_d   = StClear;
                    end
                end else if (game_full) begin
                    starter_d = ~starter_q;
                    state_d   = StClear;
                end else begin
                    turn_d  = ~turn_q;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StDone: begin
                match_done = 1'b1;
                if (start) begin
                    pl_score_d = '0;
                    pc_score_d = '0;
                    winner_d   = 2'b00;
                    starter_d  = 1'b0;
                    turn_d     = 1'b0;
                    state_d    = StClear;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            turn_q     <= 1'b0;
            starter_q  <= 1'b0;
            cnt_q      <= '0;
            move_pos_q <= 4'd0;
            pl_score_q <= '0;
            pc_score_q <= '0;
            winner_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            starter_q  <= starter_d;
            cnt_q      <= cnt_d;
            move_pos_q <= move_pos_d;
            pl_score_q <= pl_score_d;
            pc_score_q <= pc_score_d;
            winner_q   <= winner_d;
        end
    end

    assign turn         = turn_q;
    assign move_pos     = move_pos_q;
    assign pl_score     = pl_score_q;
    assign pc_score     = pc_score_q;
    assign match_winner = winner_q;

endmodule

// File: tb/tb_ttt_match_sequencer.sv
// Directed bench for ttt_match_sequencer: full games, illegal move, timeout, draw,
// match end/restart and asynchronous reset.
module tb_ttt_match_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pl_req = 1'b0, pc_req = 1'b0;
    logic [3:0] pl_pos = 4'd0, pc_pos = 4'd0;
    logic       pl_ack, pc_ack;
    logic       game_illegal = 1'b0, game_win = 1'b0, game_full = 1'b0;
    logic [1:0] game_who = 2'b00;
    logic       play, pc, board_clear, turn, timeout_flag, match_done;
    logic [3:0] move_pos;
    logic [3:0] pl_score, pc_score;
    logic [1:0] match_winner;

    int total = 0;
    int bad   = 0;

    ttt_match_sequencer #(
        .WINS_TO_MATCH(2),
        .TURN_TIMEOUT (8),
        .SCORE_W      (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pl_req      (pl_req),
        .pl_pos      (pl_pos),
        .pc_req      (pc_req),
        .pc_pos      (pc_pos),
        .pl_ack      (pl_ack),
        .pc_ack      (pc_ack),
        .game_illegal(game_illegal),
        .game_win    (game_win),
        .game_who    (game_who),
        .game_full   (game_full),
        .play        (play),
        .pc          (pc),
        .move_pos    (move_pos),
        .board_clear (board_clear),
        .turn        (turn),
        .timeout_flag(timeout_flag),
        .pl_score    (pl_score),
        .pc_score    (pc_score),
        .match_done  (match_done),
        .match_winner(match_winner)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in WAIT with turn == side; ends in the state following CHECK (or WAIT if illegal).
    task automatic do_move(input logic side, input logic [3:0] pos, input logic ill,
                           input logic win, input logic [1:0] who, input logic full);
        if (side) begin
            pc_req = 1'b1;
            pc_pos = pos;
        end else begin
            pl_req = 1'b1;
            pl_pos = pos;
        end
        step();
        chk("issue_play", play, 1);
        chk("issue_pc", pc, side);
        chk("issue_pos", move_pos, pos);
        chk("issue_ack", side ? pc_ack : pl_ack, 1);
        chk("issue_other_ack", side ? pl_ack : pc_ack, 0);
        pl_req = 1'b0;
        pc_req = 1'b0;
        game_illegal = ill;
        step();
        game_illegal = 1'b0;
        if (ill) return;
        game_win  = win;
        game_who  = who;
        game_full = full;
        step();
        step();
        game_win  = 1'b0;
        game_who  = 2'b00;
        game_full = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst_board_clear", board_clear, 0);
        chk("rst_move_pos", move_pos, 0);
        chk("rst_match_done", match_done, 0);
        reset = 1'b0;
        step();
        chk("idle_turn", turn, 0);
        chk("idle_play", play, 0);
        chk("idle_scores", {pl_score, pc_score}, 0);

        // Game 1: player wins on its third move.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("g1_clear", board_clear, 1);
        step();
        chk("g1_wait_clear_gone", board_clear, 0);
        chk("g1_first_turn", turn, 0);
        do_move(1'b0, 4'd1, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("g1_turn_after_pl", turn, 1);
        do_move(1'b1, 4'd4, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("g1_turn_after_pc", turn, 0);
        do_move(1'b0, 4'd2, 1'b0, 1'b0, 2'b00, 1'b0);
        do_move(1'b1, 4'd5, 1'b0, 1'b0, 2'b00, 1'b0);
        do_move(1'b0, 4'd3, 1'b0, 1'b1, 2'b01, 1'b0);
        chk("g1_win_clear", board_clear, 1);
        chk("g1_pl_score", pl_score, 1);
        chk("g1_pc_score", pc_score, 0);
        chk("g1_not_done", match_done, 0);
        step();
        chk("g2_starter_pc", turn, 1);

        // Game 2: both requests on player turn, illegal computer move, player wins match.
        do_move(1'b1, 4'd7, 1'b0, 1'b0, 2'b00, 1'b0);
        pc_req = 1'b1;
        pc_pos = 4'd9;
        do_move(1'b0, 4'd1, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("g2_turn_after_both", turn, 1);
        do_move(1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 1'b0);
        chk("ill_turn_kept", turn, 1);
        chk("ill_no_play", play, 0);
        chk("ill_score", pl_score, 1);
        do_move(1'b1, 4'd6, 1'b0, 1'b0, 2'b00, 1'b0);
        do_move(1'b0, 4'd8, 1'b0, 1'b1, 2'b01, 1'b0);
        chk("done_flag", match_done, 1);
        chk("done_winner", match_winner, 2'b01);
        chk("done_pl_score", pl_score, 2);
        chk("done_no_clear", board_clear, 0);
        step();
        chk("done_held", match_done, 1);

        // Restart from DONE.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_clear", board_clear, 1);
        chk("restart_pl_score", pl_score, 0);
        chk("restart_winner", match_winner, 0);
        chk("restart_done", match_done, 0);
        step();
        chk("restart_turn", turn, 0);

        // Player idles: timeout on the eighth WAIT cycle.
        for (int i = 0; i < 6; i++) begin
            step();
            chk("to_early", timeout_flag, 0);
        end
        step();
        chk("to_flag", timeout_flag, 1);
        chk("to_no_play", play, 0);
        step();
        chk("to_turn", turn, 1);
        chk("to_flag_pulse", timeout_flag, 0);

        // Computer wins a game, then a draw.
        do_move(1'b1, 4'd5, 1'b0, 1'b1, 2'b10, 1'b0);
        chk("pcwin_clear", board_clear, 1);
        chk("pcwin_score", pc_score, 1);
        step();
        chk("pcwin_next_starter", turn, 1);
        do_move(1'b1, 4'd2, 1'b0, 1'b0, 2'b00, 1'b1);
        chk("draw_clear", board_clear, 1);
        chk("draw_pc_score", pc_score, 1);
        chk("draw_pl_score", pl_score, 0);
        step();
        chk("draw_starter_toggled", turn, 0);
        step();

        // Asynchronous reset mid-WAIT.
        reset = 1'b1;
        #1;
        chk("arst_pc_score", pc_score, 0);
        chk("arst_move_pos", move_pos, 0);
        chk("arst_turn", turn, 0);
        chk("arst_flags", {play, pc, pl_ack, pc_ack, board_clear, timeout_flag, match_done}, 0);
        chk("arst_winner", match_winner, 0);
        step();
        reset = 1'b0;
        step();
        chk("arst_idle_no_clear", board_clear, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("arst_restart_clear", board_clear, 1);
        step();
        chk("arst_restart_turn", turn, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
